mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded MEM wait.
// Define MC_CTRL_EXT_EN to add addiu (09h) and j (02h) to the decoded set.
module mc_controller #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic               ir_we,
    output logic               reg_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic [1:0]         wa_sel,
    output logic [1:0]         wd_sel,
    output logic               ext_op,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         npc_sel,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               illegal,
    output logic               mem_timeout
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_ADDU, K_SUBU, K_JR, K_SLL, K_ORI, K_LW, K_SW,
        K_BEQ, K_LUI, K_JAL, K_ADDIU, K_J, K_ILL
    } kind_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(6);
    localparam logic [7:0]         TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur, nxt;
    kind_t      kind;
    logic       run;
    logic       set_to;
    logic       to_q;
    logic [7:0] wait_cnt;

    assign state       = cur;
    assign mem_timeout = to_q;

    // run rises on the first edge after reset release; it also gates every
    // control output to zero the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_comb begin
        kind = K_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   kind = K_ADDU;
                    6'h23:   kind = K_SUBU;
                    6'h08:   kind = K_JR;
                    6'h00:   kind = K_SLL;
                    default: kind = K_ILL;
                endcase
            end
            6'h0D: kind = K_ORI;
            6'h23: kind = K_LW;
            6'h2B: kind = K_SW;
            6'h04: kind = K_BEQ;
            6'h0F: kind = K_LUI;
            6'h03: kind = K_JAL;
`ifdef MC_CTRL_EXT_EN
            6'h09: kind = K_ADDIU;
            6'h02: kind = K_J;
`endif
            default: kind = K_ILL;
        endcase
    end

    always_comb begin
        nxt        = cur;
        set_to     = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        wa_sel     = 2'd0;
        wd_sel     = 2'd0;
        ext_op     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        npc_sel    = 2'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (run) begin
            case (cur)
                FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = DECODE;
                end
                DECODE: begin
                    nxt = FETCH;
                    case (kind)
                        K_JAL, K_J: begin
                            pc_we      = 1'b1;
                            npc_sel    = 2'd1;
                            reg_we     = (kind == K_JAL);
                            wa_sel     = (kind == K_JAL) ? 2'd2 : 2'd0;
                            wd_sel     = (kind == K_JAL) ? 2'd2 : 2'd0;
                            instr_done = 1'b1;
                        end
                        K_JR: begin
                            pc_we      = 1'b1;
                            npc_sel    = 2'd2;
                            instr_done = 1'b1;
                        end
                        K_ILL: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: nxt = EXEC;
                    endcase
                end
                EXEC: begin
                    alu_src = (kind == K_ORI) || (kind == K_LUI) || (kind == K_LW)
                           || (kind == K_SW)  || (kind == K_ADDIU);
                    ext_op  = (kind == K_LW) || (kind == K_SW) || (kind == K_BEQ)
                           || (kind == K_ADDIU);
                    case (kind)
                        K_SUBU, K_BEQ: alu_op = ALU_SUB;
                        K_ORI:         alu_op = ALU_OR;
                        K_LUI:         alu_op = ALU_LUI;
                        K_SLL:         alu_op = ALU_SLL;
                        default:       alu_op = ALU_ADD;
                    endcase
                    if (kind == K_BEQ) begin
                        pc_we      = zero;
                        npc_sel    = 2'd3;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end else if (kind == K_LW || kind == K_SW) begin
                        nxt = MEM;
                    end else begin
                        nxt = WB;
                    end
                end
                MEM: begin
                    mem_re = (kind == K_LW);
                    mem_we = (kind == K_SW);
                    // ready on the final allowed cycle still wins over the abort
                    if (mem_ready) begin
                        instr_done = (kind != K_LW);
                        nxt        = (kind == K_LW) ? WB : FETCH;
                    end else if (wait_cnt == TO_LAST) begin
                        set_to     = 1'b1;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                end
                WB: begin
                    reg_we     = 1'b1;
                    wa_sel     = (kind == K_ADDU || kind == K_SUBU || kind == K_SLL) ? 2'd1 : 2'd0;
                    wd_sel     = (kind == K_LW) ? 2'd1 : 2'd0;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                default: nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= FETCH;
            wait_cnt <= 8'd0;
            to_q     <= 1'b0;
        end else begin
            cur <= nxt;
            if (set_to) to_q <= 1'b1;
            if (run && cur == MEM && !mem_ready && wait_cnt != TO_LAST)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus a randomized
// instruction stream checked cycle-by-cycle against a per-instruction phase model.
module tb_mc_controller;

    localparam int MEM_TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, ext_op, alu_src;
    logic [1:0] wa_sel, wd_sel, npc_sel;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic       instr_done, illegal, mem_timeout;

    int nvec = 0;
    int nerr = 0;
    logic exp_to = 1'b0;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we, ir_we, reg_we, mem_re, mem_we;
        logic [1:0] wa, wd;
        logic       ext, src;
        logic [3:0] alu;
        logic [1:0] npc;
        logic       done, ill, to;
    } vec_t;

    mc_controller #(.ALUOP_W(4), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .wa_sel(wa_sel), .wd_sel(wd_sel),
        .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op), .npc_sel(npc_sel),
        .state(state), .instr_done(instr_done), .illegal(illegal),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t sample();
        return '{state, pc_we, ir_we, reg_we, mem_re, mem_we, wa_sel, wd_sel,
                 ext_op, alu_src, alu_op, npc_sel, instr_done, illegal, mem_timeout};
    endfunction

    function automatic string name_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h21: return "addu";
                6'h23: return "subu";
                6'h08: return "jr";
                6'h00: return "sll";
                default: return "ill";
            endcase
        end
        case (o)
            6'h03: return "jal";
            6'h0D: return "ori";
            6'h23: return "lw";
            6'h2B: return "sw";
            6'h04: return "beq";
            6'h0F: return "lui";
`ifdef MC_CTRL_EXT_EN
            6'h09: return "addiu";
            6'h02: return "j";
`endif
            default: return "ill";
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input string nm);
        case (nm)
            "subu", "beq": return 4'd1;
            "ori":         return 4'd2;
            "lui":         return 4'd4;
            "sll":         return 4'd6;
            default:       return 4'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one instruction: w = mem_ready wait cycles (>= MEM_TO never ready);
    // abort_at >= 0 pulls rst_n low in that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int w, input int abort_at);
        vec_t  q[$];
        vec_t  e;
        string nm;
        bit    term;
        int    nmem, midx;
        nm   = name_of(o, f);
        term = 1'b0;
        e = '0; e.st = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1; q.push_back(e);
        e = '0; e.st = 3'd1;
        if (nm == "jal") begin
            e.pc_we = 1; e.npc = 2'd1; e.reg_we = 1; e.wa = 2'd2; e.wd = 2'd2; e.done = 1; term = 1;
        end else if (nm == "j") begin
            e.pc_we = 1; e.npc = 2'd1; e.done = 1; term = 1;
        end else if (nm == "jr") begin
            e.pc_we = 1; e.npc = 2'd2; e.done = 1; term = 1;
        end else if (nm == "ill") begin
            e.ill = 1; e.done = 1; term = 1;
        end
        q.push_back(e);
        if (!term) begin
            e = '0; e.st = 3'd2; e.alu = alu_of(nm);
            e.src = (nm == "ori" || nm == "lui" || nm == "lw" || nm == "sw" || nm == "addiu");
            e.ext = (nm == "lw" || nm == "sw" || nm == "beq" || nm == "addiu");
            if (nm == "beq") begin e.pc_we = z; e.npc = 2'd3; e.done = 1; term = 1; end
            q.push_back(e);
        end
        if (!term && (nm == "lw" || nm == "sw")) begin
            nmem = (w < MEM_TO) ? w + 1 : MEM_TO;
            for (int i = 0; i < nmem; i++) begin
                e = '0; e.st = 3'd3; e.mem_re = (nm == "lw"); e.mem_we = (nm == "sw");
                if (i == nmem - 1 && (nm == "sw" || w >= MEM_TO)) e.done = 1;
                q.push_back(e);
            end
            if (nm == "sw" || w >= MEM_TO) term = 1;
        end
        if (!term) begin
            e = '0; e.st = 3'd4; e.reg_we = 1; e.done = 1;
            e.wa = (nm == "addu" || nm == "subu" || nm == "sll") ? 2'd1 : 2'd0;
            e.wd = (nm == "lw") ? 2'd1 : 2'd0;
            q.push_back(e);
        end
        midx = 0;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin op = o; funct = f; zero = z; end
            if (q[k].st == 3'd3) begin
                mem_ready = (midx == w);
                midx++;
            end else begin
                mem_ready = 1'($urandom);
            end
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk($sformatf("%s abort", nm), sample(), vec_t'('0));
                exp_to = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                #1 chk($sformatf("%s post-release", nm), sample(), vec_t'('0));
                return;
            end
            #1;
            e = q[k]; e.to = exp_to;
            chk($sformatf("%s cyc%0d", nm, k), sample(), e);
            if (q[k].st == 3'd3 && q[k].done && w >= MEM_TO) exp_to = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        #1 chk("reset", sample(), vec_t'('0));
        exp_to = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release", sample(), vec_t'('0));
    endtask

    logic [5:0] tbl_op [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B,
                                6'h04, 6'h0F, 6'h03, 6'h3F, 6'h09, 6'h02, 6'h00};
    logic [5:0] tbl_fn [14] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};

    initial begin
        int idx, w;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release", sample(), vec_t'('0));
        run_instr(6'h00, 6'h21, 1'b0, 0, -1);           // addu
        run_instr(6'h23, 6'h00, 1'b0, 3, -1);           // lw, 3 wait cycles
        run_instr(6'h04, 6'h00, 1'b1, 0, -1);           // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, -1);           // beq not taken
        run_instr(6'h2B, 6'h00, 1'b0, 100, -1);         // sw timeout
        run_instr(6'h2B, 6'h00, 1'b0, MEM_TO - 1, -1);  // ready on last allowed cycle
        run_instr(6'h03, 6'h00, 1'b0, 0, -1);           // jal
        run_instr(6'h3F, 6'h00, 1'b0, 0, -1);           // illegal op
        run_instr(6'h09, 6'h00, 1'b0, 0, -1);
        run_instr(6'h02, 6'h00, 1'b0, 0, -1);
        do_reset();                                      // clears sticky timeout
        run_instr(6'h23, 6'h00, 1'b0, 5, 4);            // reset during MEM of lw
        run_instr(6'h00, 6'h00, 1'b0, 0, -1);           // sll right after release
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 13));
            w   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            run_instr(tbl_op[idx], tbl_fn[idx], 1'($urandom), w, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
